// File: rtl/ber_checker.sv
// ber_checker: decimates the filter output, slices it to bits, finds the PRBS delay and counts bit errors
// Ports:
//   i_clk, i_rst     clock (rising edge), asynchronous active-high reset
//   i_valid, i_data  new signed (18,15) sample this cycle
//   i_phase          sample index within each symbol that is kept
//   i_ref_bit        transmitter reference bit, taken on each symbol strobe
//   i_restart        clears counters and restarts the delay search
//   o_locked         high once a delay has been chosen
//   o_delay          best delay so far / locked delay
//   o_bit_count      symbols compared while locked (saturating)
//   o_err_count      mismatches while locked (saturating)
module ber_checker #(
    parameter int NB_INPUT = 18,
    parameter int OS       = 4,
    parameter int NB_PHASE = 2,
    parameter int REF_LEN  = 511,
    parameter int NB_COUNT = 64,
    localparam int NB_DELAY = $clog2(REF_LEN),
    localparam int NB_ERR   = $clog2(REF_LEN + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic [NB_INPUT-1:0] i_data,
    input  logic [NB_PHASE-1:0] i_phase,
    input  logic                i_ref_bit,
    input  logic                i_restart,
    output logic                o_locked,
    output logic [NB_DELAY-1:0] o_delay,
    output logic [NB_COUNT-1:0] o_bit_count,
    output logic [NB_COUNT-1:0] o_err_count
);
    typedef enum logic {S_SEARCH, S_LOCK} state_t;
    state_t              r_state;
    logic [NB_PHASE-1:0] r_phase_cnt;
    // the oldest reference bit is never addressed once the new bit is shifted in, so it is not stored
    logic [REF_LEN-2:0]  r_ref_sr;
    logic                r_stb;
    logic                r_mis;
    logic [NB_DELAY-1:0] r_d;
    logic [NB_DELAY-1:0] r_best;
    logic [NB_DELAY-1:0] r_win_cnt;
    logic [NB_ERR-1:0]   r_err_win;
    logic [NB_ERR-1:0]   r_min_err;
    logic [NB_COUNT-1:0] r_bit_count;
    logic [NB_COUNT-1:0] r_err_count;
    logic                w_strobe;
    logic [REF_LEN-1:0]  w_ref_now;
    logic [NB_ERR-1:0]   w_err_tot;
    logic                w_win_end;
    logic                w_last_d;
    logic                w_better;
    logic [NB_DELAY-1:0] w_lock_d;
    logic                w_unused_data;

    assign w_strobe      = i_valid && (r_phase_cnt == i_phase);
    assign w_ref_now     = {r_ref_sr, i_ref_bit};
    assign w_err_tot     = r_err_win + NB_ERR'(r_mis);
    assign w_win_end     = r_win_cnt == NB_DELAY'(REF_LEN - 1);
    assign w_last_d      = r_d == NB_DELAY'(REF_LEN - 1);
    assign w_better      = w_err_tot < r_min_err;
    assign w_lock_d      = w_better ? r_d : r_best;
    assign w_unused_data = ^i_data[NB_INPUT-2:0];

    assign o_locked    = r_state == S_LOCK;
    assign o_delay     = r_best;
    assign o_bit_count = r_bit_count;
    assign o_err_count = r_err_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_SEARCH;
            r_phase_cnt <= '0;
            r_ref_sr    <= '0;
            r_stb       <= 1'b0;
            r_mis       <= 1'b0;
            r_d         <= '0;
            r_best      <= '0;
            r_win_cnt   <= '0;
            r_err_win   <= '0;
            r_min_err   <= '1;
            r_bit_count <= '0;
            r_err_count <= '0;
        end else begin
            if (i_valid)
                r_phase_cnt <= (r_phase_cnt == NB_PHASE'(OS - 1)) ? '0 : r_phase_cnt + 1'b1;
            // the reference keeps tracking the transmitter even on a restart strobe
            if (w_strobe) begin
                r_ref_sr <= w_ref_now[REF_LEN-2:0];
                r_mis    <= i_data[NB_INPUT-1] ^ w_ref_now[r_d];
            end
            r_stb <= w_strobe && !i_restart;
            if (i_restart) begin
                r_state     <= S_SEARCH;
                r_d         <= '0;
                r_best      <= '0;
                r_win_cnt   <= '0;
                r_err_win   <= '0;
                r_min_err   <= '1;
                r_bit_count <= '0;
                r_err_count <= '0;
            end else if (r_stb) begin
                if (r_state == S_LOCK) begin
                    if (!(&r_bit_count))
                        r_bit_count <= r_bit_count + 1'b1;
                    if (r_mis && !(&r_err_count))
                        r_err_count <= r_err_count + 1'b1;
                end else if (w_win_end) begin
                    r_win_cnt <= '0;
                    r_err_win <= '0;
                    if (w_better) begin
                        r_min_err <= w_err_tot;
                        r_best    <= r_d;
                    end
                    // r_d doubles as the compare index once locked
                    if (w_err_tot == '0 || w_last_d) begin
                        r_state <= S_LOCK;
                        r_d     <= w_lock_d;
                    end else begin
                        r_d <= r_d + 1'b1;
                    end
                end else begin
                    r_win_cnt <= r_win_cnt + 1'b1;
                    r_err_win <= w_err_tot;
                end
            end
        end
    end
endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker: directed PRBS4 alignment, error, phase, saturation and restart tests for ber_checker
module tb_ber_checker;
    localparam int OS = 4;
    localparam int L  = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        ref_bit = 1'b0;
    logic        restart = 1'b0;
    logic [17:0] data = '0;
    logic [1:0]  phase = '0;

    logic        lock_a, lock_b;
    logic [3:0]  dly_a, dly_b;
    logic [63:0] bits_a, errs_a;
    logic [3:0]  bits_b, errs_b;

    int checks = 0;
    int errors = 0;

    bit     ref_h[8192];
    bit     det_h[8192];
    int     n, s0, pc, min_err, best;
    bit     m_lock;
    int     m_delay;
    longint m_bits, m_errs;
    bit     v_lock;
    int     v_delay;
    longint v_bits, v_errs;

    logic [3:0] lfsr = 4'b1000;
    bit         ref_sym[4096];
    int         sym = 0;

    always #5 clk = ~clk;

    ber_checker #(.REF_LEN(L)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_phase(phase),
        .i_ref_bit(ref_bit), .i_restart(restart), .o_locked(lock_a), .o_delay(dly_a),
        .o_bit_count(bits_a), .o_err_count(errs_a)
    );

    ber_checker #(.REF_LEN(L), .NB_COUNT(4)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_phase(phase),
        .i_ref_bit(ref_bit), .i_restart(restart), .o_locked(lock_b), .o_delay(dly_b),
        .o_bit_count(bits_b), .o_err_count(errs_b)
    );

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic longint sat15(longint x);
        return x > 15 ? 15 : x;
    endfunction

    function automatic bit ref_at(int i);
        return i < 0 ? 1'b0 : ref_h[i];
    endfunction

    task automatic search_reset(int start);
        s0 = start;
        m_lock = 0;
        m_delay = 0;
        m_bits = 0;
        m_errs = 0;
        min_err = 1 << 30;
        best = 0;
    endtask

    task automatic model_reset();
        n = 0;
        pc = 0;
        search_reset(0);
        v_lock = 0;
        v_delay = 0;
        v_bits = 0;
        v_errs = 0;
    endtask

    // outputs after an edge show every strobe before that edge; the strobe at this edge shows one edge later
    task automatic model_edge();
        bit stb;
        stb = valid && (pc == int'(phase));
        if (valid) pc = (pc + 1) % OS;
        if (restart) begin
            v_lock = 0;
            v_bits = 0;
            v_errs = 0;
        end else begin
            v_lock = m_lock;
            v_delay = m_delay;
            v_bits = m_bits;
            v_errs = m_errs;
        end
        if (stb) begin
            ref_h[n] = ref_bit;
            det_h[n] = data[17];
        end
        if (restart) begin
            search_reset(stb ? n + 1 : n);
        end else if (stb) begin
            if (m_lock) begin
                m_bits++;
                if (det_h[n] != ref_at(n - m_delay)) m_errs++;
            end else if ((n - s0 + 1) % L == 0) begin
                int w;
                int e;
                w = (n - s0) / L;
                e = 0;
                for (int j = n - L + 1; j <= n; j++)
                    if (det_h[j] != ref_at(j - w)) e++;
                if (e < min_err) begin
                    min_err = e;
                    best = w;
                end
                if (e == 0 || w == L - 1) begin
                    m_lock = 1;
                    m_delay = best;
                end
            end
        end
        if (stb) n++;
    endtask

    task automatic compare();
        check("locked", lock_a, v_lock);
        check("locked_sat", lock_b, v_lock);
        check("bit_count", bits_a, v_bits);
        check("err_count", errs_a, v_errs);
        check("bit_count_sat", bits_b, sat15(v_bits));
        check("err_count_sat", errs_b, sat15(v_errs));
        if (v_lock) begin
            check("delay", dly_a, v_delay);
            check("delay_sat", dly_b, v_delay);
        end
    endtask

    task automatic cycle(bit v, logic [17:0] d, bit r, bit rs);
        valid = v;
        data = d;
        ref_bit = r;
        restart = rs;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    function automatic logic [17:0] smp(bit b);
        return b ? 18'h3E000 : 18'h02000;
    endfunction

    // PRBS4 x^4+x^3+1; data is the reference delayed by 5 symbols
    task automatic next_sym(output bit r, output bit db);
        bit nb;
        nb = lfsr[3] ^ lfsr[2];
        lfsr = {lfsr[2:0], nb};
        ref_sym[sym] = nb;
        db = sym >= 5 ? ref_sym[sym - 5] : 1'b0;
        r = nb;
        sym++;
    endtask

    task automatic send_sym(logic [3:0] inv);
        bit r, db;
        next_sym(r, db);
        for (int j = 0; j < OS; j++) cycle(1'b1, smp(db ^ inv[j]), r, 1'b0);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_locked"}, lock_a, 0);
        check({tag, "_delay"}, dly_a, 0);
        check({tag, "_bits"}, bits_a, 0);
        check({tag, "_errs"}, errs_a, 0);
        check({tag, "_sat_locked"}, lock_b, 0);
        check({tag, "_sat_bits"}, bits_b, 0);
        check({tag, "_sat_errs"}, errs_b, 0);
    endtask

    initial begin
        bit r, db;
        model_reset();
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 89; i++) send_sym(4'h0);
        check("align_pre_lock", lock_a, 0);
        next_sym(r, db);
        cycle(1'b1, smp(db), r, 1'b0);
        check("align_strobe90_edge", lock_a, 0);
        cycle(1'b1, smp(db), r, 1'b0);
        check("align_locked", lock_a, 1);
        check("align_delay", dly_a, 5);
        cycle(1'b1, smp(db), r, 1'b0);
        cycle(1'b1, smp(db), r, 1'b0);
        for (int i = 0; i < 10; i++) send_sym(4'h0);
        check("align_bits", bits_a, 10);
        check("align_errs", errs_a, 0);

        for (int k = 0; k < 1000; k++) send_sym(k % 100 == 99 ? 4'hF : 4'h0);
        check("inject_bits", bits_a, 1010);
        check("inject_errs", errs_a, 10);
        check("inject_sat_bits", bits_b, 15);
        check("inject_sat_errs", errs_b, 10);

        phase = 2'd2;
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("phase2_restart", lock_a, 0);
        for (int i = 0; i < 95; i++) send_sym(4'b1011);
        check("phase2_locked", lock_a, 1);
        check("phase2_delay", dly_a, 5);
        check("phase2_bits", bits_a, 5);
        check("phase2_errs", errs_a, 0);

        phase = 2'd1;
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("phase1_restart", lock_a, 0);
        for (int i = 0; i < 224; i++) send_sym(4'b1011);
        check("phase1_searching", lock_a, 0);
        send_sym(4'b1011);
        check("phase1_locked", lock_a, 1);
        check("phase1_delay", dly_a, 0);

        phase = 2'd2;
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 90; i++) send_sym(4'b1011);
        check("sat_locked", lock_a, 1);
        for (int i = 0; i < 20; i++) send_sym(4'hF);
        check("sat_full_bits", bits_a, 20);
        check("sat_full_errs", errs_a, 20);
        check("sat_bits", bits_b, 15);
        check("sat_errs", errs_b, 15);

        next_sym(r, db);
        cycle(1'b1, smp(~db), r, 1'b0);
        cycle(1'b1, smp(~db), r, 1'b0);
        cycle(1'b1, smp(~db), r, 1'b1);
        check("rs_same_locked", lock_a, 0);
        check("rs_same_bits", bits_a, 0);
        check("rs_same_errs", errs_a, 0);
        check("rs_same_sat_errs", errs_b, 0);
        cycle(1'b1, smp(~db), r, 1'b0);

        for (int i = 0; i < 90; i++) send_sym(4'b1011);
        check("relock", lock_a, 1);
        check("relock_delay", dly_a, 5);
        for (int i = 0; i < 3; i++) send_sym(4'b1011);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ber_checker.md
# ber_checker

Downstream receive-side stage for the FIR pulse-shaping filter output. It takes the filter's 18-bit (18,15) oversampled stream and decimates it by OS at a selectable phase. It slices each kept sample to a bit, aligns that bit stream against the transmitter's reference PRBS bit stream by exhaustive delay search, and then counts bits and bit errors for BER measurement.

## Interface
- NB_INPUT, 18, input sample width, signed (18,15)
- OS, 4, oversampling factor (samples per symbol, ≥2)
- NB_PHASE, 2, width of phase select, ≥ clog2(OS)
- REF_LEN, 511, reference buffer depth; delay search range 0..REF_LEN-1; symbols per search window
- NB_COUNT, 64, width of bit and error counters
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  i_data holds a new sample this cycle
- i_data  in  NB_INPUT  signed filter output
- i_phase  in  NB_PHASE  sample index within symbol to keep (0..OS-1)
- i_ref_bit  in  1  transmitter reference bit, sampled on every symbol strobe
- i_restart  in  1  synchronous pulse: clear counters, return to SEARCH
- o_locked  out  1  1 in LOCK state
- o_delay  out  clog2(REF_LEN)  best/locked delay
- o_bit_count  out  NB_COUNT  symbols compared in LOCK
- o_err_count  out  NB_COUNT  mismatches in LOCK

## Operation
- Phase counter: 0..OS-1, advances on each i_valid, wraps. Strobe = i_valid && counter == i_phase. i_phase changes take effect on the next sample; the caller pulses i_restart after a phase change.
- Slicer: detected bit = i_data[NB_INPUT-1] (sign). Negative → 1, zero/positive → 0, matching the transmitter mapping 0→+, 1→−.
- Reference buffer: REF_LEN-bit shift register. On strobe, i_ref_bit shifts into ref_sr[0]. ref_sr[k] is the bit from k strobes earlier. Compared bit = ref_sr[delay] after the shift (the current-strobe value is included).
- FSM states SEARCH and LOCK.
- SEARCH:
  - Candidate delay d starts at 0. Each window is REF_LEN strobes; err_win counts mismatches at delay d.
  - At window end, if err_win < min_err (strict): min_err ← err_win and best ← d. Ties keep the earlier delay.
  - If err_win == 0: lock immediately with delay = d.
  - Otherwise, if d == REF_LEN-1: go to LOCK with delay = best. Else d ← d+1, err_win ← 0.
  - min_err is initialised to all-ones at SEARCH entry.
- LOCK: each strobe increments o_bit_count; each mismatch also increments o_err_count. Both counters saturate at 2^NB_COUNT-1 and hold. LOCK persists until i_restart or reset.
- i_restart: takes priority over any strobe in the same cycle. It clears counters, d, err_win, and min_err, and enters SEARCH. The reference buffer is not cleared.
- Reset values: phase counter 0, ref_sr all 0, state SEARCH, o_locked 0, o_delay 0, o_bit_count 0, o_err_count 0. All are applied asynchronously on i_rst assertion. Reset asserted mid-LOCK or mid-SEARCH discards all progress.

## Timing
- A sample accepted with a strobe at edge k updates ref_sr, the slicer register, and the comparison at edge k. Counters and err_win reflect it after edge k+1: one-cycle latency.
- o_locked rises one cycle after the final strobe of the deciding window. o_delay is valid from the same cycle.
- Back-to-back strobes (OS samples on consecutive cycles) are handled every symbol with no stall. Non-strobe cycles leave all state except the phase counter unchanged.
- Worst-case search duration: REF_LEN² strobes.

## Test plan
- Reset: assert i_rst with no clock → all outputs 0 immediately. Deassert and drive no i_valid for 20 cycles → outputs unchanged.
- Alignment (REF_LEN=15, OS=4, i_phase=0): drive PRBS4 (x⁴+x³+1) on i_ref_bit. Drive i_data = +0x02000/−0x02000 per bit, same sequence delayed 5 symbols, each sample held 4 valids. Expect o_locked=1 with o_delay=5 one cycle after strobe 90 (early zero-error lock), then o_err_count=0.
- Error injection: after lock, invert the sign of 1 symbol in every 100 for 1000 symbols → o_bit_count=1000, o_err_count=10.
- Phase select: i_phase=2, only sample index 2 of each symbol correct, other three inverted → lock at correct delay with 0 errors. Switch to i_phase=1 and pulse i_restart → o_locked=0, then the new search completes without a zero-error window.
- Saturation: NB_COUNT=4, force all-error data in LOCK → o_err_count reaches 15 and holds; o_bit_count holds at 15.
- Restart/reset mid-operation: i_restart in the same cycle as a mismatched strobe → counters 0, o_locked 0, no increment. Async i_rst mid-LOCK → all outputs 0 before the next edge.
